// File: rtl/mrc_pkg.sv
// mrc_pkg: shared defaults and element/matrix types for matrix_result_collector
package mrc_pkg;
  localparam int DATA_W = 17;
  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int NUM_ELEMS = ROWS * COLS;
  typedef logic [DATA_W-1:0] elem_t;
  typedef elem_t [NUM_ELEMS-1:0] matrix_t;
endpackage

// File: rtl/mrc_buffer.sv
// mrc_buffer: DEPTH-entry circular FIFO of completed matrices; ports clk/NRST, push/wdata, pop/rdata (zero when empty), level/full/empty
module mrc_buffer
  import mrc_pkg::*;
#(
  parameter int W = NUM_ELEMS * DATA_W,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   NRST,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  // A push into a full buffer is accepted only when the head leaves on the same edge
  assign do_push = push & (~full | pop);
  assign do_pop = pop & ~empty;
  assign rdata = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      level <= (do_push & ~do_pop) ? level + 1'b1 : (~do_push & do_pop) ? level - 1'b1 : level;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/matrix_result_collector.sv
// matrix_result_collector: assembles ROWS*COLS strobed elements into row-major matrices and offers them on valid/ready
// Ports: clk, NRST (async active-low), in_data/in_strobe (element stream), flush (drop partial matrix),
// m_data/m_valid/m_ready (matrix handshake), fill_idx, level, overflow (sticky drop flag), clr_ovf.
// Optional MRC_MAX_TRACK_EN adds m_max, the unsigned maximum element of the head matrix.
module matrix_result_collector
  import mrc_pkg::*;
#(
  parameter int DATA_W = mrc_pkg::DATA_W,
  parameter int ROWS = mrc_pkg::ROWS,
  parameter int COLS = mrc_pkg::COLS,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          NRST,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_strobe,
  input  logic                          flush,
  output logic [ROWS*COLS*DATA_W-1:0]   m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(ROWS*COLS)-1:0]  fill_idx,
  output logic [$clog2(DEPTH):0]        level,
`ifdef MRC_MAX_TRACK_EN
  output logic [DATA_W-1:0]             m_max,
`endif
  output logic                          overflow,
  input  logic                          clr_ovf
);
  localparam int N = ROWS * COLS;
  localparam int FW = $clog2(N);
  localparam int MW = N * DATA_W;
`ifdef MRC_MAX_TRACK_EN
  localparam int BW = MW + DATA_W;
`else
  localparam int BW = MW;
`endif
  logic [MW-1:0] asm_q, asm_next;
  logic [BW-1:0] push_data, head;
  logic last, commit, pop, full, empty;
  assign last = fill_idx == FW'(N - 1);
  assign commit = in_strobe & ~flush & last;
  assign pop = m_valid & m_ready;
  assign m_valid = ~empty;
  assign m_data = head[MW-1:0];
  // The committed word includes the element arriving on the committing edge
  always_comb begin
    asm_next = asm_q;
    if (in_strobe) asm_next[fill_idx*DATA_W +: DATA_W] = in_data;
  end
`ifdef MRC_MAX_TRACK_EN
  logic [DATA_W-1:0] max_q, max_next;
  assign max_next = (in_strobe && in_data > max_q) ? in_data : max_q;
  assign push_data = {max_next, asm_next};
  assign m_max = head[BW-1 -: DATA_W];
  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) max_q <= '0;
    else max_q <= (flush | commit) ? '0 : max_next;
  end
`else
  assign push_data = asm_next;
`endif
  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      fill_idx <= '0;
      asm_q <= '0;
      overflow <= 1'b0;
    end else begin
      fill_idx <= flush ? '0 : in_strobe ? (last ? '0 : fill_idx + 1'b1) : fill_idx;
      asm_q <= (flush | commit) ? '0 : asm_next;
      // A drop on the same edge as clr_ovf keeps the flag set
      overflow <= (commit & full & ~pop) | (overflow & ~clr_ovf);
    end
  end
  mrc_buffer #(.W(BW), .DEPTH(DEPTH)) u_buf (
    .clk(clk),
    .NRST(NRST),
    .push(commit),
    .pop(pop),
    .wdata(push_data),
    .rdata(head),
    .level(level),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_matrix_result_collector.sv
// tb_matrix_result_collector: directed self-checking bench for matrix_result_collector
module tb_matrix_result_collector;
  import mrc_pkg::*;
  logic clk = 1'b0;
  logic NRST = 1'b0;
  logic [16:0] in_data = '0;
  logic in_strobe = 1'b0, flush = 1'b0, m_ready = 1'b0, clr_ovf = 1'b0;
  logic [67:0] m_data;
  logic m_valid, overflow;
  logic [1:0] fill_idx, level;
`ifdef MRC_MAX_TRACK_EN
  logic [16:0] m_max;
`endif
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  matrix_result_collector dut (
    .clk(clk), .NRST(NRST), .in_data(in_data), .in_strobe(in_strobe), .flush(flush),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .fill_idx(fill_idx), .level(level),
`ifdef MRC_MAX_TRACK_EN
    .m_max(m_max),
`endif
    .overflow(overflow), .clr_ovf(clr_ovf)
  );
  function automatic matrix_t mk(input int a, input int b, input int c, input int d);
    matrix_t r;
    r[0] = elem_t'(a); r[1] = elem_t'(b); r[2] = elem_t'(c); r[3] = elem_t'(d);
    return r;
  endfunction
  task automatic strobe(input int v);
    in_data = 17'(v); in_strobe = 1'b1;
    @(negedge clk);
    in_strobe = 1'b0;
  endtask
  task automatic push4(input int b);
    for (int i = 0; i < 4; i++) strobe(b + i);
  endtask
  task automatic test_reset;
    #1;
    total++; if (m_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", m_valid); else passed++;
    total++; if (level !== 2'd0) $display("FAIL rst_level got %0d exp 0", level); else passed++;
    total++; if (fill_idx !== 2'd0) $display("FAIL rst_fill got %0d exp 0", fill_idx); else passed++;
    total++; if (m_data !== 68'h0) $display("FAIL rst_data got %h exp 0", m_data); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL rst_ovf got %0b exp 0", overflow); else passed++;
    @(negedge clk); NRST = 1'b1;
  endtask
  task automatic test_fill;
    strobe(1); strobe(2);
    total++; if (fill_idx !== 2'd2) $display("FAIL fill_mid_idx got %0d exp 2", fill_idx); else passed++;
    strobe(3);
    total++; if (m_valid !== 1'b0) $display("FAIL fill_early_valid got %0b exp 0", m_valid); else passed++;
    strobe(4);
    total++; if (m_valid !== 1'b1) $display("FAIL fill_valid got %0b exp 1", m_valid); else passed++;
    total++; if (m_data !== mk(1, 2, 3, 4)) $display("FAIL fill_data got %h exp %h", m_data, mk(1, 2, 3, 4)); else passed++;
    total++; if (level !== 2'd1) $display("FAIL fill_level got %0d exp 1", level); else passed++;
    total++; if (fill_idx !== 2'd0) $display("FAIL fill_wrap got %0d exp 0", fill_idx); else passed++;
    m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
    total++; if (m_valid !== 1'b0) $display("FAIL fill_pop_valid got %0b exp 0", m_valid); else passed++;
    total++; if (m_data !== 68'h0) $display("FAIL fill_pop_data got %h exp 0", m_data); else passed++;
  endtask
  task automatic test_overflow;
    push4(1); push4(5);
    strobe(9); strobe(10); strobe(11);
    clr_ovf = 1'b1; strobe(12); clr_ovf = 1'b0;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_set got %0b exp 1", overflow); else passed++;
    total++; if (level !== 2'd2) $display("FAIL ovf_level got %0d exp 2", level); else passed++;
    total++; if (m_data !== mk(1, 2, 3, 4)) $display("FAIL ovf_head got %h exp %h", m_data, mk(1, 2, 3, 4)); else passed++;
    total++; if (fill_idx !== 2'd0) $display("FAIL ovf_wrap got %0d exp 0", fill_idx); else passed++;
    clr_ovf = 1'b1; @(negedge clk); clr_ovf = 1'b0;
    total++; if (overflow !== 1'b0) $display("FAIL ovf_clr got %0b exp 0", overflow); else passed++;
    m_ready = 1'b1; @(negedge clk);
    total++; if (m_data !== mk(5, 6, 7, 8)) $display("FAIL ovf_pop1 got %h exp %h", m_data, mk(5, 6, 7, 8)); else passed++;
    total++; if (level !== 2'd1) $display("FAIL ovf_pop1_level got %0d exp 1", level); else passed++;
    @(negedge clk); m_ready = 1'b0;
    total++; if (m_valid !== 1'b0) $display("FAIL ovf_pop2_valid got %0b exp 0", m_valid); else passed++;
    total++; if (m_data !== 68'h0) $display("FAIL ovf_pop2_data got %h exp 0", m_data); else passed++;
  endtask
  task automatic test_flush;
    strobe(7); strobe(8);
    in_data = 17'd9; in_strobe = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_strobe = 1'b0; flush = 1'b0;
    total++; if (fill_idx !== 2'd0) $display("FAIL flush_idx got %0d exp 0", fill_idx); else passed++;
    total++; if (level !== 2'd0) $display("FAIL flush_level got %0d exp 0", level); else passed++;
    push4(1);
    total++; if (level !== 2'd1) $display("FAIL flush_after_level got %0d exp 1", level); else passed++;
    total++; if (m_data !== mk(1, 2, 3, 4)) $display("FAIL flush_after_data got %h exp %h", m_data, mk(1, 2, 3, 4)); else passed++;
    m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
    total++; if (level !== 2'd0) $display("FAIL flush_drain got %0d exp 0", level); else passed++;
  endtask
  task automatic test_back_to_back;
    push4(1); push4(5);
    strobe(9); strobe(10); strobe(11);
    m_ready = 1'b1; strobe(12); m_ready = 1'b0;
    total++; if (overflow !== 1'b0) $display("FAIL b2b_ovf got %0b exp 0", overflow); else passed++;
    total++; if (level !== 2'd2) $display("FAIL b2b_level got %0d exp 2", level); else passed++;
    total++; if (m_data !== mk(5, 6, 7, 8)) $display("FAIL b2b_head got %h exp %h", m_data, mk(5, 6, 7, 8)); else passed++;
    m_ready = 1'b1; @(negedge clk);
    total++; if (m_data !== mk(9, 10, 11, 12)) $display("FAIL b2b_new got %h exp %h", m_data, mk(9, 10, 11, 12)); else passed++;
    @(negedge clk); m_ready = 1'b0;
    total++; if (m_valid !== 1'b0) $display("FAIL b2b_empty got %0b exp 0", m_valid); else passed++;
  endtask
  task automatic test_async_reset;
    push4(1); push4(5); strobe(9); strobe(10); strobe(11); strobe(12);
    total++; if (overflow !== 1'b1) $display("FAIL ar_pre_ovf got %0b exp 1", overflow); else passed++;
    m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
    strobe(20); strobe(21);
    total++; if (fill_idx !== 2'd2) $display("FAIL ar_pre_idx got %0d exp 2", fill_idx); else passed++;
    total++; if (level !== 2'd1) $display("FAIL ar_pre_level got %0d exp 1", level); else passed++;
    #2 NRST = 1'b0;
    #1;
    total++; if (m_valid !== 1'b0) $display("FAIL ar_valid got %0b exp 0", m_valid); else passed++;
    total++; if (level !== 2'd0) $display("FAIL ar_level got %0d exp 0", level); else passed++;
    total++; if (fill_idx !== 2'd0) $display("FAIL ar_idx got %0d exp 0", fill_idx); else passed++;
    total++; if (m_data !== 68'h0) $display("FAIL ar_data got %h exp 0", m_data); else passed++;
    @(negedge clk); NRST = 1'b1;
    push4(1);
    total++; if (m_data !== mk(1, 2, 3, 4)) $display("FAIL ar_after got %h exp %h", m_data, mk(1, 2, 3, 4)); else passed++;
    m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
  endtask
`ifdef MRC_MAX_TRACK_EN
  task automatic test_max;
    strobe('h12); strobe('h1FFFF); strobe(3); strobe(4);
    push4(1);
    total++; if (m_max !== 17'h1FFFF) $display("FAIL max_first got %h exp 1ffff", m_max); else passed++;
    total++; if (m_data !== mk('h12, 'h1FFFF, 3, 4)) $display("FAIL max_first_data got %h exp %h", m_data, mk('h12, 'h1FFFF, 3, 4)); else passed++;
    m_ready = 1'b1; @(negedge clk);
    total++; if (m_max !== 17'h4) $display("FAIL max_second got %h exp 4", m_max); else passed++;
    @(negedge clk); m_ready = 1'b0;
    total++; if (m_max !== 17'h0) $display("FAIL max_empty got %h exp 0", m_max); else passed++;
  endtask
`endif
  initial begin
    test_reset;
    test_fill;
    test_overflow;
    test_flush;
    test_back_to_back;
    test_async_reset;
`ifdef MRC_MAX_TRACK_EN
    test_max;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/matrix_result_collector.md
Name: matrix_result_collector

Overview:
- Sits directly downstream of matrix_multiplier and consumes its serial result stream (`out`/`out_strobe`).
- Gathers ROWS*COLS consecutive results into one complete result matrix and buffers up to DEPTH matrices.
- Presents each complete matrix as one flattened word on a valid/ready interface for the next consumer (writeback/DMA).
- The upstream side has no backpressure, so loss is detected and flagged instead of stalled.

Parameters:
- DATA_W, 17, width of one result element; matches multiplier `out`.
- ROWS, 2, result matrix rows.
- COLS, 2, result matrix columns.
- DEPTH, 2, completed-matrix buffer entries; power of two, >=2.

Ports:
- clk  in  1  system clock, rising edge.
- NRST  in  1  asynchronous active-low reset.
- in_data  in  DATA_W  result element from matrix_multiplier `out`.
- in_strobe  in  1  element valid, one cycle per element (from `out_strobe`).
- flush  in  1  synchronous; discards the partially filled matrix.
- m_data  out  ROWS*COLS*DATA_W  head matrix, row-major; element k at bits [k*DATA_W +: DATA_W].
- m_valid  out  1  head matrix available.
- m_ready  in  1  consumer accepts head matrix.
- fill_idx  out  $clog2(ROWS*COLS)  index of the next element to be written.
- level  out  $clog2(DEPTH)+1  number of completed matrices buffered.
- overflow  out  1  sticky; a completed matrix was dropped.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset (NRST=0, async): fill_idx=0, level=0, m_valid=0, m_data=0, overflow=0, partial assembly register zeroed.
- Fill: on each clk edge with in_strobe=1, in_data is written to assembly slot fill_idx, then fill_idx increments.
- Order is row-major: idx 0=(0,0), 1=(0,1), 2=(1,0), 3=(1,1) for the 2x2 default.
- Commit: the strobe that writes idx ROWS*COLS-1 wraps fill_idx to 0 and commits the assembled matrix, including that final element, to the buffer tail in the same edge.
- Latency: if the buffer was empty, m_valid=1 and m_data is valid on the cycle after the final strobe (1-cycle latency).
- Handshake: a pop occurs on an edge with m_valid & m_ready.
  - m_data/m_valid may not change while m_valid=1 and m_ready=0.
  - m_valid = (level != 0).
  - m_data = 0 when level = 0.
- Full: a commit when level==DEPTH with no pop that edge drops the matrix. Buffer contents are unchanged, overflow<=1, fill_idx still wraps to 0.
- Simultaneous commit and pop:
  - When full: both happen, no drop, level unchanged.
  - When empty: the commit lands and becomes head on the next cycle; there is no same-cycle bypass.
- flush=1: fill_idx<=0 and partial elements are discarded. Buffered matrices are unaffected.
  - flush wins over a coincident in_strobe; that element is discarded too, with no commit.
- clr_ovf=1: overflow<=0, unless a drop occurs on the same edge, in which case the drop wins and overflow=1.
- Reset mid-fill or mid-handshake discards everything immediately (async), with no partial output.
- Arithmetic: none on data; elements are stored bit-exact. level is a saturating counter in 0..DEPTH.

Optional Feature:
- Macro: MRC_MAX_TRACK_EN.
- Defined:
  - Adds output m_max [DATA_W-1:0], the unsigned maximum element of the head matrix.
  - The maximum is computed incrementally during fill, stored alongside each buffered matrix, and obeys the same stability/zero-when-empty rules as m_data.
  - flush resets the running max to 0.
- Undefined: port m_max and the running-max logic are absent; all other behaviour is identical.

Decomposition:
- Package mrc_pkg holds:
  - DATA_W default;
  - typedef elem_t (logic [DATA_W-1:0]);
  - typedef matrix_t (packed array [ROWS*COLS] of elem_t);
  - localparam NUM_ELEMS.
- Sub-module mrc_buffer: a DEPTH-entry circular FIFO of matrix_t (plus optional max) with push/pop/level/full/empty.
- The top level holds the fill counter, assembly register, flush/overflow logic and handshake glue.

Test Plan:
- Reset then strobes 1,2,3,4 -> next cycle m_valid=1, m_data elements {1,2,3,4} row-major, level=1, fill_idx=0.
- With m_ready=0, push three matrices ({1..4},{5..8},{9..12}) into DEPTH=2 -> level=2, overflow=1, head stays {1..4}; then m_ready=1 for two cycles -> pops {1..4} then {5..8}, m_valid=0, m_data=0.
- Strobes 7,8, then flush, then strobes 1,2,3,4 -> single matrix {1,2,3,4}; the 7,8 elements are never output.
- Full buffer, final strobe coincident with m_ready=1 -> no overflow, level stays 2, new matrix appears after the older remaining one.
- Assert NRST=0 mid-fill after 2 strobes with 1 matrix buffered -> m_valid=0, level=0, fill_idx=0 immediately; clr_ovf then clears a previously set overflow.
- MRC_MAX_TRACK_EN: strobes 0x12,0x1FFFF,0x3,0x4 -> m_max=0x1FFFF with that matrix; next matrix {1,2,3,4} -> m_max=4.
